ptch_fusion_integrator: RTL and testbench

// Downstream of the inertial interface. Consumes each raw pitch-rate/AZ sample pair
// (accepted on the vld strobe) and produces fusion-corrected platform pitch for balance_cntrl.
// It runs in two phases:
// - Optional startup phase: calibrates the gyro rate offset.
// - Run phase: integrates the offset-compensated pitch rate, and nudges the integral toward
//   the accelerometer-derived pitch by a fixed fusion step every sample.

---
 rtl/ptch_fusion_integrator.sv | 147 ++++++++++++++
 tb/tb_ptch_fusion_integrator.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ptch_fusion_integrator.sv
// Pitch fusion integrator: integrates offset-compensated pitch rate and
// pulls the integral toward accelerometer-derived pitch by a fixed step.
// An optional startup phase learns the gyro rate offset as a sample average.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_CAL  | accumulating 2**CAL_LOG2 raw rate samples to learn rt_off
//   ST_RUN  | integrating each sample into ptch_int; terminal until reset
module ptch_fusion_integrator #(
   parameter bit          CAL_EN         = 1'b1,
   parameter int          CAL_LOG2       = 4,
   parameter logic [15:0] PTCH_RT_OFFSET = 16'h0050,
   parameter logic [15:0] AZ_OFFSET      = 16'h00A0,
   parameter int          AZ_SCALE       = 327,
   parameter int          FUSION_STEP    = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               vld,
   input  logic signed [15:0] ptch_rt,
   input  logic signed [15:0] AZ,
   output logic signed [15:0] ptch,
   output logic               ptch_vld,
   output logic               cal_done
);

   typedef enum logic {ST_CAL, ST_RUN} state_t;

   localparam state_t             ST_RESET   = CAL_EN ? ST_CAL : ST_RUN;
   localparam logic signed [15:0] RT_OFF_RST = CAL_EN ? 16'sd0 : PTCH_RT_OFFSET;
   localparam logic signed [25:0] AZ_SCALE_W = 26'(AZ_SCALE);
   localparam logic [27:0]        FUS_POS    = 28'(FUSION_STEP);
   localparam logic [27:0]        FUS_NEG    = 28'(-FUSION_STEP);
   localparam logic [26:0]        INT_MAX    = 27'h3FF_FFFF;
   localparam logic [26:0]        INT_MIN    = 27'h400_0000;

   state_t                   state, state_nxt;
   logic                     cal_step, cal_last, run_step;

   logic signed [15:0]       rt_off;
   logic signed [26:0]       ptch_int;
   logic signed [23:0]       cal_acc;
   logic [CAL_LOG2-1:0]      cal_cnt;

   logic [16:0]              rt_diff, az_diff;
   logic signed [15:0]       rt_comp, az_comp;
   logic signed [25:0]       az_prod;
   logic signed [26:0]       ptch_az;
   logic [27:0]              fus, sum28;
   logic [26:0]              nxt;
   logic signed [23:0]       cal_sum;

   // Clamp a 17-bit difference back into 16-bit signed range.
   function automatic logic signed [15:0] sat16(input logic [16:0] v);
      if (v[16] != v[15]) begin
         return v[16] ? 16'sh8000 : 16'sh7FFF;
      end
      return $signed(v[15:0]);
   endfunction

   // Offset compensation, accel-to-pitch scaling, fusion nudge and saturating integration.
   always_comb begin
      rt_diff = {ptch_rt[15], ptch_rt} - {rt_off[15], rt_off};
      az_diff = {AZ[15], AZ} - {AZ_OFFSET[15], AZ_OFFSET};
      rt_comp = sat16(rt_diff);
      az_comp = sat16(az_diff);
      az_prod = $signed({{10{az_comp[15]}}, az_comp}) * AZ_SCALE_W;
      ptch_az = 27'(az_prod >>> 13);
      fus     = '0;
      if (ptch_az > ptch_int) begin
         fus = FUS_POS;
      end else if (ptch_az < ptch_int) begin
         fus = FUS_NEG;
      end
      sum28 = {ptch_int[26], ptch_int} - {{12{rt_comp[15]}}, rt_comp} + fus;
      if (sum28[27] != sum28[26]) begin
         nxt = sum28[27] ? INT_MIN : INT_MAX;
      end else begin
         nxt = sum28[26:0];
      end
      cal_sum = cal_acc + $signed({{8{ptch_rt[15]}}, ptch_rt});
   end

   // Phase register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RESET;
      end else begin
         state <= state_nxt;
      end
   end

   // Next phase and per-sample qualifiers.
   always_comb begin
      state_nxt = state;
      cal_step  = 1'b0;
      cal_last  = 1'b0;
      run_step  = 1'b0;
      case (state)
         ST_CAL: begin
            if (vld) begin
               cal_step = 1'b1;
               if (cal_cnt == '1) begin
                  cal_last  = 1'b1;
                  state_nxt = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            run_step = vld;
         end
         default: state_nxt = ST_RESET;
      endcase
   end

   // Calibration accumulator; the final sample's average becomes the rate offset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cal_acc <= '0;
         cal_cnt <= '0;
         rt_off  <= RT_OFF_RST;
      end else if (cal_step) begin
         cal_acc <= cal_sum;
         cal_cnt <= cal_cnt + 1'b1;
         if (cal_last) begin
            rt_off <= 16'(cal_sum >>> CAL_LOG2);
         end
      end
   end

   // Integral update and output strobe, both only for samples taken in run phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptch_int <= '0;
         ptch_vld <= 1'b0;
      end else begin
         ptch_vld <= run_step;
         if (run_step) begin
            ptch_int <= $signed(nxt);
         end
      end
   end

   assign ptch     = ptch_int[26:11];
   assign cal_done = (state == ST_RUN);

endmodule

// File: tb/tb_ptch_fusion_integrator.sv
// Bench for ptch_fusion_integrator: one instance with fixed offset (u0) and one
// that calibrates (u1). A reference model predicts each fused pitch; a monitor
// compares every ptch_vld pulse against the predicted queue.
module tb_ptch_fusion_integrator;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [1:0]       vld = '0;
   logic [1:0][15:0] rt_in = '0;
   logic [1:0][15:0] az_in = '0;
   logic [1:0][15:0] ptch_o;
   logic [1:0]       ptch_vld;
   logic [1:0]       cal_done;

   int n_chk  = 0;
   int n_fail = 0;
   int pulses [2] = '{0, 0};

   longint m_int [2];
   longint m_off [2];
   longint m_csum [2];
   int     m_ccnt [2];
   bit     m_run [2];
   longint exp_q0 [$];
   longint exp_q1 [$];

   always #10 clk = ~clk;

   ptch_fusion_integrator #(.CAL_EN(1'b0)) u0 (
      .clk(clk), .rst_n(rst_n), .vld(vld[0]), .ptch_rt(rt_in[0]), .AZ(az_in[0]),
      .ptch(ptch_o[0]), .ptch_vld(ptch_vld[0]), .cal_done(cal_done[0]));

   ptch_fusion_integrator #(.CAL_EN(1'b1), .CAL_LOG2(4)) u1 (
      .clk(clk), .rst_n(rst_n), .vld(vld[1]), .ptch_rt(rt_in[1]), .AZ(az_in[1]),
      .ptch(ptch_o[1]), .ptch_vld(ptch_vld[1]), .cal_done(cal_done[1]));

   function automatic longint clamp(input longint v, input longint lo, input longint hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   function automatic longint s16(input logic [15:0] v);
      return longint'($signed(v));
   endfunction

   task automatic check(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_int[i]  = 0;
         m_csum[i] = 0;
         m_ccnt[i] = 0;
      end
      m_off[0] = 80;
      m_off[1] = 0;
      m_run[0] = 1'b1;
      m_run[1] = 1'b0;
      exp_q0.delete();
      exp_q1.delete();
   endtask

   // Reference behaviour of one accepted sample.
   task automatic model_step(input int i, input longint rt, input longint az);
      longint rtc, azc, paz, fus;
      if (!m_run[i]) begin
         m_csum[i] += rt;
         m_ccnt[i]++;
         if (m_ccnt[i] == 16) begin
            m_off[i] = m_csum[i] >>> 4;
            m_run[i] = 1'b1;
         end
      end else begin
         rtc = clamp(rt - m_off[i], -32768, 32767);
         azc = clamp(az - 160, -32768, 32767);
         paz = (azc * 327) >>> 13;
         fus = (paz > m_int[i]) ? 1024 : ((paz < m_int[i]) ? -1024 : 0);
         m_int[i] = clamp(m_int[i] - rtc + fus, -(64'sd1 <<< 26), (64'sd1 <<< 26) - 1);
         if (i == 0) exp_q0.push_back(m_int[i] >>> 11);
         else        exp_q1.push_back(m_int[i] >>> 11);
      end
   endtask

   task automatic send(input int i, input logic [15:0] r, input logic [15:0] a);
      @(negedge clk);
      vld      = '0;
      vld[i]   = 1'b1;
      rt_in[i] = r;
      az_in[i] = a;
      model_step(i, s16(r), s16(a));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         vld = '0;
      end
   endtask

   task automatic chk_reset();
      check("rst_ptch0", s16(ptch_o[0]), 0);
      check("rst_ptch1", s16(ptch_o[1]), 0);
      check("rst_ptch_vld", longint'(ptch_vld), 0);
      check("rst_cal_done", longint'(cal_done), 1);
   endtask

   task automatic pulse_reset();
      idle(2);
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      chk_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Scoreboard monitor: every ptch_vld pulse must match the oldest prediction.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ptch_vld[0]) begin
            pulses[0]++;
            if (exp_q0.size() == 0) check("u0_unexpected_vld", 1, 0);
            else check("u0_ptch", s16(ptch_o[0]), exp_q0.pop_front());
         end
         if (ptch_vld[1]) begin
            pulses[1]++;
            if (exp_q1.size() == 0) check("u1_unexpected_vld", 1, 0);
            else check("u1_ptch", s16(ptch_o[1]), exp_q1.pop_front());
         end
      end
   end

   initial begin
      int p0;
      longint hold;
      model_reset();
      repeat (2) @(negedge clk);
      chk_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Fixed offset, zero-compensated inputs: ptch stays 0, one pulse per sample.
      p0 = pulses[0];
      for (int k = 0; k < 100; k++) begin
         send(0, 16'h0050, 16'h00A0);
         idle(1);
      end
      idle(2);
      check("t1_pulses", pulses[0] - p0, 100);
      check("t1_ptch", s16(ptch_o[0]), 0);

      // Constant rate of -2048 after offset, back-to-back samples.
      for (int k = 0; k < 2047; k++) send(0, 16'h0050 - 16'd2048, 16'h00A0);
      idle(2);
      check("t2_ptch", s16(ptch_o[0]), 1024);

      // Full-scale negative rate: integral must saturate, never wrap.
      for (int k = 0; k < 5000; k++) send(0, 16'h8000, 16'h00A0);
      idle(2);
      check("t4_ptch_sat", s16(ptch_o[0]), 32767);

      // Random samples with bursts of up to three back-to-back.
      pulse_reset();
      for (int k = 0; k < 150; k++) begin
         int burst;
         burst = $urandom_range(3, 1);
         for (int b = 0; b < burst; b++)
            send(0, 16'($urandom), 16'($urandom));
         idle($urandom_range(2, 1));
      end
      idle(2);
      hold = m_int[0] >>> 11;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         rt_in[0] = 16'($urandom);
         az_in[0] = 16'($urandom);
         check("t5_hold_no_vld", s16(ptch_o[0]), hold);
      end

      // Calibration to a constant offset, then zero-compensated run samples.
      for (int k = 0; k < 16; k++) begin
         send(1, 16'h0030, 16'h00A0);
         idle(1);
         check("t3_cal_done", longint'(cal_done[1]), longint'(m_run[1]));
      end
      for (int k = 0; k < 5; k++) send(1, 16'h0030, 16'h00A0);
      idle(2);
      check("t3_ptch_zero", s16(ptch_o[1]), 0);

      // Reset in the middle of calibration restarts it from sample 0.
      pulse_reset();
      for (int k = 0; k < 8; k++) send(1, 16'($urandom_range(400, 0)) - 16'd200, 16'h00A0);
      idle(1);
      check("t6_mid_cal", longint'(cal_done[1]), 0);
      pulse_reset();
      for (int k = 0; k < 16; k++) begin
         send(1, 16'($urandom_range(2000, 0)) - 16'd1000, 16'($urandom));
         idle(1);
         check("t6_cal_done", longint'(cal_done[1]), longint'(m_run[1]));
      end
      for (int k = 0; k < 200; k++) begin
         send(1, 16'($urandom_range(4000, 0)) - 16'd2000, 16'($urandom));
         if (($urandom & 1) != 0) idle(1);
      end
      idle(3);

      check("u0_queue_drained", exp_q0.size(), 0);
      check("u1_queue_drained", exp_q1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
